// File: rtl/aes_engine_stream.sv
// Stream-side AES engine: packs 32-bit plaintext words into 128-bit blocks, runs them through the
// cipher core with a start/done handshake, then emits the result words. Optional AES_ENGINE_PERF_CNT_EN adds a busy-cycle counter.
module aes_engine_stream #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_blocks_i,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              core_start_o,
  output logic [127:0]      core_block_o,
  input  logic              core_done_i,
  input  logic [127:0]      core_result_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  block_cnt_o
`ifdef AES_ENGINE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles_o
`endif
);

  localparam int BLK_W = 128;
  localparam int IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CRYPT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   num_blocks_q;
  logic [CNT_W-1:0]   block_cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   word_idx_q;
  logic [BLK_W-1:0]   block_q;
  logic [BLK_W-1:0]   result_q;
  logic               start_pend_q;
  logic               done_q;

  // Handshake strobes, all qualified by the current state.
  logic start_acc, in_hs, out_hs, core_take, word_last;

  assign cnt_inc   = block_cnt_q + CNT_W'(1);
  assign word_last = (word_idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    core_start_o = 1'b0;
    start_acc    = 1'b0;
    in_hs        = 1'b0;
    out_hs       = 1'b0;
    core_take    = 1'b0;
    case (state_q)
      IDLE: begin
        start_acc = start_i & enable_i;
        if (start_acc && (num_blocks_i != '0)) state_d = LOAD;
      end
      LOAD: begin
        in_ready_o = enable_i;
        in_hs      = in_valid_i & enable_i;
        if (in_hs && word_last) state_d = CRYPT;
      end
      CRYPT: begin
        // done is only meaningful once the start pulse has actually gone out
        core_start_o = start_pend_q & enable_i;
        core_take    = ~start_pend_q & core_done_i;
        if (core_take) state_d = DRAIN;
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        out_hs      = out_ready_i;
        if (out_hs && word_last) state_d = (cnt_inc == num_blocks_q) ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      num_blocks_q <= '0;
      block_cnt_q  <= '0;
      word_idx_q   <= '0;
      block_q      <= '0;
      result_q     <= '0;
      start_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      num_blocks_q <= '0;
      block_cnt_q  <= '0;
      word_idx_q   <= '0;
      block_q      <= '0;
      result_q     <= '0;
      start_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (start_acc) begin
        num_blocks_q <= num_blocks_i;
        block_cnt_q  <= '0;
        word_idx_q   <= '0;
        done_q       <= (num_blocks_i == '0);
      end
      // Shifting in from the bottom leaves the first word in [127:96].
      if (in_hs) begin
        block_q    <= {block_q[BLK_W-WORD_W-1:0], in_data_i};
        word_idx_q <= word_last ? '0 : word_idx_q + IDX_W'(1);
        if (word_last) start_pend_q <= 1'b1;
      end
      if (core_start_o) start_pend_q <= 1'b0;
      if (core_take) result_q <= core_result_i;
      if (out_hs) begin
        result_q   <= {result_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        word_idx_q <= word_last ? '0 : word_idx_q + IDX_W'(1);
        if (word_last) begin
          block_cnt_q <= cnt_inc;
          if (cnt_inc == num_blocks_q) done_q <= 1'b1;
        end
      end
    end
  end

  assign out_data_o   = result_q[BLK_W-1 -: WORD_W];
  assign core_block_o = block_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign block_cnt_o  = block_cnt_q;

`ifdef AES_ENGINE_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of busy cycles, restarted by each accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (clear || start_acc) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: doc/aes_engine_stream.md
Name: aes_engine_stream

Overview:
- Engine-side responder to the AES HWPE controller.
- Accepts the controller's start/enable/clear commands and consumes the plaintext source stream as 32-bit words.
- Assembles each group of words into a 128-bit block, hands the block to the AES cipher core through a start/done handshake, then serializes the 128-bit result onto the ciphertext sink stream.
- Reports busy/done flags back to the controller.

Parameters:
- WORD_W, 32, stream word width in bits.
- WORDS_PER_BLOCK, 4, words per AES block; WORD_W*WORDS_PER_BLOCK must equal 128.
- CNT_W, 16, width of the block count and block counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear; same effect as reset.
- enable_i  in  1  engine enable from controller.
- start_i  in  1  start pulse from controller.
- num_blocks_i  in  CNT_W  blocks to process; latched on accepted start.
- in_data_i  in  WORD_W  plaintext word.
- in_valid_i  in  1  plaintext valid.
- in_ready_o  out  1  plaintext ready.
- out_data_o  out  WORD_W  ciphertext word.
- out_valid_o  out  1  ciphertext valid.
- out_ready_i  in  1  ciphertext ready.
- core_start_o  out  1  one-cycle start pulse to cipher core.
- core_block_o  out  128  assembled plaintext block, stable while in CRYPT.
- core_done_i  in  1  cipher core result valid.
- core_result_i  in  128  cipher core result.
- busy_o  out  1  high whenever the state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- block_cnt_o  out  CNT_W  blocks fully emitted so far.

Behaviour:
- Reset or clear:
  - State goes to IDLE.
  - All outputs go to 0; counters, block register and result register are zeroed.
  - Any in-flight block is discarded.
  - Reset and clear take effect mid-operation with no further handshakes.
- States and transitions:
  - IDLE:
    - start_i is ignored unless enable_i is high.
    - On an accepted start, num_blocks_i is latched and block_cnt is zeroed.
    - If num_blocks_i == 0, stay in IDLE and pulse done_o on the next cycle; no stream traffic occurs.
    - Otherwise go to LOAD.
  - LOAD:
    - in_ready_o = enable_i.
    - Each in_valid_i & in_ready_o handshake stores one word. The first word goes to bits [127:96], then downward to [31:0].
    - The cycle after the WORDS_PER_BLOCK-th handshake, the state is CRYPT.
  - CRYPT:
    - core_start_o is high only on the first CRYPT cycle, and only if enable_i is high; otherwise the pulse is deferred until enable_i returns.
    - core_done_i is ignored in the start cycle and sampled from the next cycle onward.
    - On core_done_i, core_result_i is latched and the state goes to DRAIN.
  - DRAIN:
    - out_valid_o is high from the first DRAIN cycle. out_data_o presents result[127:96] first.
    - The word index advances only on out_valid_o & out_ready_i.
    - Once asserted, out_valid_o and out_data_o stay stable until the handshake, regardless of enable_i.
    - After the last word handshake, block_cnt increments.
    - If block_cnt equals num_blocks, go to IDLE and pulse done_o in the following cycle. Otherwise go to LOAD.
- start_i while busy is ignored.
- in_ready_o is 0 outside LOAD. out_valid_o is 0 outside DRAIN.
- Minimum per-block latency with all ready/valid signals high and a 1-cycle core:
  - 4 LOAD cycles, 1 start cycle, 1 done cycle, 4 DRAIN cycles.
  - First output word appears 6 cycles after the first input handshake.
- Counters wrap modulo 2^CNT_W. num_blocks is unsigned.

Optional Feature:
- Macro: AES_ENGINE_PERF_CNT_EN.
- With the macro defined:
  - Adds output perf_cycles_o (32 bits).
  - It counts every cycle with busy_o high.
  - It clears on an accepted start, on reset and on clear.
  - It holds its value after done_o and saturates at 0xFFFFFFFF.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single block, all ready/valid signals high, 1-cycle core:
  - Stimulus: num_blocks=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - Response: core_block_o=0x00112233_44556677_8899AABB_CCDDEEFF; with core_result_i=0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A, the output words are 0x69C4E0D8, 0x6A7B0430, 0xD8CDB780, 0x70B4C55A in order; done_o pulses once; block_cnt_o=1.
- Zero blocks:
  - Stimulus: start with num_blocks=0.
  - Response: done_o high exactly 1 cycle later; in_ready_o, out_valid_o and core_start_o never assert.
- Backpressure:
  - Stimulus: out_ready_i toggles 1,0,0,1 during DRAIN.
  - Response: out_data_o holds each word stable while out_valid_o is high; no word is lost or duplicated.
- Three blocks with a 10-cycle core latency:
  - Response: exactly 3 core_start_o pulses and 12 output words; block_cnt_o steps 1, 2, 3; done_o pulses after the 12th handshake.
- Mid-operation clear:
  - Stimulus: clear asserted after 2 input words of block 1.
  - Response: next cycle busy_o=0, in_ready_o=0, block_cnt_o=0; a subsequent start runs cleanly.
- enable_i low during LOAD for 5 cycles:
  - Response: in_ready_o=0 for those cycles; word order is preserved afterwards. With AES_ENGINE_PERF_CNT_EN, perf_cycles_o includes the 5 stall cycles.
